// File: rtl/score_display_pkg.sv
// Segment/anode constants shared by the score display driver and its decoder.
// Segment order is {g,f,e,d,c,b,a}, all active-low.
package score_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [1:0] IDX_RESET = 2'd3;

  // Active-low one-hot anode enable for a digit index.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/score_display_driver_seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD nibbles
// render as a dash so corrupted scores are visible rather than misleading.
module seg7_decoder
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display_driver.sv
// Scans a 4-digit packed-BCD score onto a multiplexed common-anode display,
// with per-frame shadowing and leading-zero blanking. Define SCORE_BLINK_EN to blink while FROZEN.
module score_display_driver
  import score_display_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] SCORE,
  input  logic        FROZEN,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int          SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);

  logic [31:0] scan_cnt_reg;
  logic [1:0]  idx_reg;
  logic [15:0] shadow_reg;
  logic        live_reg;

  logic        tick;
  logic [1:0]  idx_next;
  logic [15:0] shadow_next;
  logic        live_next;
  logic [3:0]  nib_zero;
  logic [3:0]  blank;
  logic [3:0]  digit_sel;
  logic [6:0]  seg_dec;
  logic        phase_on_next;
  logic        digit_shown;
  logic [3:0]  an_next;
  logic [6:0]  seg_next;

  assign tick        = (scan_cnt_reg == SCAN_LAST);
  assign idx_next    = tick ? idx_reg + 2'd1 : idx_reg;
  // Latch only on the 3->0 step so a frame is drawn from one consistent score.
  assign shadow_next = (tick && idx_reg == 2'd3) ? SCORE : shadow_reg;
  assign live_next   = live_reg | tick;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib_zero
      assign nib_zero[gi] = (shadow_next[gi*4 +: 4] == 4'd0);
    end
  endgenerate

  always_comb begin
    blank    = 4'b0000;
    blank[3] = nib_zero[3];
    blank[2] = blank[3] & nib_zero[2];
    blank[1] = blank[2] & nib_zero[1];
  end

  assign digit_sel = shadow_next[{idx_next, 2'b00} +: 4];

  seg7_decoder u_dec (
    .bcd (digit_sel),
    .seg (seg_dec)
  );

`ifdef SCORE_BLINK_EN
  localparam int          BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);

  logic [31:0] blink_cnt_reg;
  logic        phase_on_reg;

  always_comb begin
    phase_on_next = phase_on_reg;
    if (!FROZEN)
      phase_on_next = 1'b1;
    else if (blink_cnt_reg == BLINK_LAST)
      phase_on_next = ~phase_on_reg;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      blink_cnt_reg <= 32'd0;
      phase_on_reg  <= 1'b1;
    end else if (!FROZEN) begin
      blink_cnt_reg <= 32'd0;
      phase_on_reg  <= 1'b1;
    end else begin
      blink_cnt_reg <= (blink_cnt_reg == BLINK_LAST) ? 32'd0 : blink_cnt_reg + 32'd1;
      phase_on_reg  <= phase_on_next;
    end
  end
`else
  localparam int blink_hz_unused = BLINK_HZ;
  logic frozen_unused;
  assign frozen_unused = FROZEN;
  assign phase_on_next = 1'b1;
`endif

  // Blink gates only the anodes; segments keep following the scan.
  assign digit_shown = live_next & ~blank[idx_next];
  assign an_next     = (digit_shown && phase_on_next) ? an_select(idx_next) : AN_OFF;
  assign seg_next    = digit_shown ? seg_dec : SEG_BLANK;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_cnt_reg <= 32'd0;
      idx_reg      <= IDX_RESET;
      shadow_reg   <= 16'd0;
      live_reg     <= 1'b0;
      AN           <= AN_OFF;
      SEG          <= SEG_BLANK;
      DP           <= 1'b1;
    end else begin
      scan_cnt_reg <= tick ? 32'd0 : scan_cnt_reg + 32'd1;
      idx_reg      <= idx_next;
      shadow_reg   <= shadow_next;
      live_reg     <= live_next;
      AN           <= an_next;
      SEG          <= seg_next;
      DP           <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// Self-checking bench for score_display_driver at SCAN_DIV=4, BLINK_HALF=20.
module tb_score_display_driver;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] SCORE = 16'h0000;
  logic        FROZEN = 1'b0;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  score_display_driver #(
    .CLK_HZ   (40),
    .SCAN_HZ  (10),
    .BLINK_HZ (1)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .SCORE  (SCORE),
    .FROZEN (FROZEN),
    .AN     (AN),
    .SEG    (SEG),
    .DP     (DP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] score;
    logic [15:0] an;   // slot i at an[i*4 +: 4]
    logic [27:0] seg;  // slot i at seg[i*7 +: 7]
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       chk_seg;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] ean, input logic [6:0] eseg,
                       input logic chk_seg);
    n_vec++;
    if (AN !== ean || DP !== 1'b1 || (chk_seg && SEG !== eseg)) begin
      n_bad++;
      $display("FAIL %s: got AN=%b SEG=%b DP=%b, want AN=%b SEG=%b DP=1%s", name, AN, SEG, DP,
               ean, eseg, chk_seg ? "" : " (SEG not checked)");
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg);
    exp_t e;
    e.an      = an;
    e.seg     = seg;
    e.chk_seg = (an != 4'b1111);
    sb.push_back(e);
  endtask

  // Entered just after a tick edge; leaves just after the following tick edge.
  task automatic slot(input string name, input logic chg, input logic [15:0] nscore);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, no expected value", name);
      e.an = 4'b1111; e.seg = 7'h7f; e.chk_seg = 1'b0;
    end else begin
      e = sb.pop_front();
      check(name, e.an, e.seg, e.chk_seg);
    end
    repeat (3) step();
    check({name, "_hold"}, e.an, e.seg, e.chk_seg);
    if (chg) SCORE = nscore;
    step();
  endtask

  task automatic do_reset(input string name);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check(name, 4'b1111, 7'b1111111, 1'b1);
  endtask

  task automatic dark_wait(input string name);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("%s_dark%0d", name, i), 4'b1111, 7'b1111111, 1'b0);
    end
    step();
  endtask

  initial begin
    logic [6:0] scan_seg [4];
    logic [3:0] one_hot;
    logic       off;
    logic [1:0] idx;

    vecs[0] = '{score: 16'h1234, an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{score: 16'h0007, an: {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                seg: {7'h7f, 7'h7f, 7'h7f, 7'b1111000}};
    vecs[2] = '{score: 16'h0000, an: {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                seg: {7'h7f, 7'h7f, 7'h7f, 7'b1000000}};
    vecs[3] = '{score: 16'h00A5, an: {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                seg: {7'h7f, 7'h7f, 7'b0111111, 7'b0010010}};
    vecs[4] = '{score: 16'h8090, an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                seg: {7'b0000000, 7'b1000000, 7'b0010000, 7'b1000000}};
    vecs[5] = '{score: 16'h0F00, an: {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                seg: {7'h7f, 7'b0111111, 7'b1000000, 7'b1000000}};
    vecs[6] = '{score: 16'h6000, an: {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                seg: {7'b0000010, 7'b1000000, 7'b1000000, 7'b1000000}};

    // Table-driven static scores: one full frame each after a fresh reset.
    for (int v = 0; v < 7; v++) begin
      SCORE = vecs[v].score;
      do_reset($sformatf("v%0d_reset", v));
      for (int s = 0; s < 4; s++) push(vecs[v].an[s*4 +: 4], vecs[v].seg[s*7 +: 7]);
      dark_wait($sformatf("v%0d", v));
      for (int s = 0; s < 4; s++) slot($sformatf("v%0d_d%0d", v, s), 1'b0, 16'h0);
    end

    // Mid-frame change, coincident-latch capture and a mid-frame change to higher digits.
    SCORE = 16'h0012;
    do_reset("mid_reset");
    dark_wait("mid");
    push(4'b1110, 7'b0100100);
    slot("mid_f1_d0", 1'b0, 16'h0);
    SCORE = 16'h0013;
    push(4'b1101, 7'b1111001); push(4'b1111, 7'h7f); push(4'b1111, 7'h7f);
    slot("mid_f1_d1", 1'b0, 16'h0);
    slot("mid_f1_d2", 1'b0, 16'h0);
    slot("mid_f1_d3", 1'b0, 16'h0);
    push(4'b1110, 7'b0110000); push(4'b1101, 7'b1111001); push(4'b1111, 7'h7f); push(4'b1111, 7'h7f);
    slot("mid_f2_d0", 1'b0, 16'h0);
    slot("mid_f2_d1", 1'b0, 16'h0);
    slot("mid_f2_d2", 1'b0, 16'h0);
    slot("mid_f2_d3", 1'b1, 16'h0914);
    push(4'b1110, 7'b0011001);
    slot("coin_f3_d0", 1'b0, 16'h0);
    SCORE = 16'h8888;
    push(4'b1101, 7'b1111001); push(4'b1011, 7'b0010000); push(4'b1111, 7'h7f);
    slot("coin_f3_d1", 1'b0, 16'h0);
    slot("coin_f3_d2", 1'b0, 16'h0);
    slot("coin_f3_d3", 1'b0, 16'h0);
    push(4'b1110, 7'b0000000);
    slot("coin_f4_d0", 1'b0, 16'h0);

    // Reset asserted in the cycle whose edge would otherwise be a tick.
    repeat (2) step();
    SCORE = 16'h0056;
    do_reset("rst_tick");
    push(4'b1110, 7'b0000010); push(4'b1101, 7'b0010010);
    dark_wait("rst_tick");
    slot("rst_tick_d0", 1'b0, 16'h0);
    slot("rst_tick_d1", 1'b0, 16'h0);

    // FROZEN: blinks only when the macro is built in; scan is otherwise untouched.
    scan_seg[0] = 7'b0011001; scan_seg[1] = 7'b0110000;
    scan_seg[2] = 7'b0100100; scan_seg[3] = 7'b1111001;
    SCORE = 16'h1234;
    do_reset("blink_reset");
    for (int e = 1; e <= 80; e++) begin
      step();
`ifdef SCORE_BLINK_EN
      off = (e > 10) && (e <= 70) && ((((e - 10) / 20) % 2) == 1);
`else
      off = 1'b0;
`endif
      if (e < 4) begin
        check($sformatf("blink_e%0d", e), 4'b1111, 7'h7f, 1'b0);
      end else begin
        idx     = 2'(((e / 4) + 3) % 4);
        one_hot = 4'b0001 << idx;
        check($sformatf("blink_e%0d", e), off ? 4'b1111 : ~one_hot, scan_seg[idx], 1'b1);
      end
      if (e == 10) FROZEN = 1'b1;
      if (e == 70) FROZEN = 1'b0;
    end

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
